mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the 5-stage MIPS core. It registers the MEM-stage result and drives the register-file write port (we/waddr/wdata) and the HI/LO write port one cycle later.
- It performs big-endian load-data extraction and sign/zero extension, including the LWL/LWR merges, before the register.
- It honours the pipeline stall vector and flush, inserting bubbles so that no spurious register-file write ever occurs.

Parameters:
- DATA_W, 32, datapath width (RegBus)
- REG_AW, 5, register address width (RegAddrBus, RegNumLog2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_mem  in  1  MEM stage stalled (stall vector bit 4)
- stall_wb  in  1  WB stage stalled (stall vector bit 5)
- flush  in  1  exception flush; kills the instruction entering WB
- mem_wd  in  REG_AW  destination register
- mem_wreg  in  1  register write enable
- mem_wdata  in  DATA_W  ALU/move result (used when no load)
- mem_load_op  in  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_rdata  in  DATA_W  aligned word returned by data RAM
- mem_rt_old  in  DATA_W  current rt value (LWL/LWR merge source)
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DATA_W  HI/LO values
- wb_wd  out  REG_AW  to regfile waddr
- wb_wreg  out  1  to regfile we
- wb_wdata  out  DATA_W  to regfile wdata
- wb_whilo  out  1  to hilo_reg we
- wb_hi, wb_lo  out  DATA_W  to hilo_reg

Behaviour:
- Reset: while rst=1, all outputs are 0 (asynchronous, no clock needed). The first capture happens on the first rising edge after deassertion.
- Latency: exactly 1 cycle from MEM inputs to wb_* outputs. Outputs come straight from flops with no combinational path to any output.
- Update priority on each rising edge, highest first:
  - flush=1: bubble.
  - stall_mem=1 and stall_wb=0: bubble.
  - stall_mem=0: capture the inputs.
  - Otherwise (both stalls set): hold all registers.
- Bubble definition: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_whilo=0, wb_hi=0, wb_lo=0.
- stall_mem=0 with stall_wb=1 is illegal per the ctrl contract. Treat it as a capture and flag it with a simulation assertion.
- Captured wdata is a function of mem_load_op. Byte lane 0 (addr_lo=0) is bits [31:24].
  - NONE: mem_wdata.
  - LB/LBU: selected byte, sign-/zero-extended to 32 bits.
  - LH/LHU: addr_lo[1]=0 selects [31:16], addr_lo[1]=1 selects [15:0], then sign-/zero-extended. addr_lo[0] is ignored because alignment exceptions are raised in MEM.
  - LW: mem_rdata. addr_lo is ignored.
  - LWL, by addr_lo:
    - 0: mem[31:0]
    - 1: {mem[23:0], rt[7:0]}
    - 2: {mem[15:0], rt[15:0]}
    - 3: {mem[7:0], rt[23:0]}
  - LWR, by addr_lo:
    - 0: {rt[31:8], mem[31:24]}
    - 1: {rt[31:16], mem[31:16]}
    - 2: {rt[31:24], mem[31:8]}
    - 3: mem[31:0]
- A load with mem_wreg=0 still captures wdata; it has no architectural effect.
- wb_wd=0 with wb_wreg=1 is passed through unchanged; the regfile discards writes to $0.
- HI/LO fields are captured independently of the load path. A register write and a HI/LO write in the same instruction are both propagated.
- Reset asserted mid-stall clears the held state immediately. After reset releases, the stage emits bubbles until the first capture.

Decomposition:
- Shared defines file gets:
  - LOAD_OP_* codes (3-bit).
  - Stall-vector bit indices.
  - RegBus, RegAddrBus, ZeroWord, WriteEnable/WriteDisable.
- One combinational sub-module, load_align, maps (load_op, addr_lo, rdata, rt_old, wdata_in) to wdata_out. It is unit-testable in isolation.
- mem_wb_stage contains only the pipeline register and the stall/flush priority logic around load_align.

Test Plan:
- Reset: rst=1 mid-cycle with prior wb_wreg=1 -> all outputs 0 asynchronously, before the next edge.
- Byte loads: mem_rdata=0x8142_F3A5.
  - LB addr_lo=2 -> wb_wdata=0xFFFF_FFF3.
  - LBU addr_lo=2 -> 0x0000_00F3.
  - LH addr_lo=0 -> 0xFFFF_8142.
  - LHU addr_lo=2 -> 0x0000_F3A5.
  - Each appears one cycle after capture.
- Unaligned merges: mem_rdata=0x1122_3344, rt_old=0xAABB_CCDD.
  - LWL addr_lo=1 -> 0x2233_44DD.
  - LWR addr_lo=1 -> 0xAABB_1122.
  - LWR addr_lo=3 -> 0x1122_3344.
- Stalls:
  - stall_mem=1, stall_wb=1 for 3 cycles with wb_wreg=1, wb_wd=8 -> outputs held all 3 cycles.
  - Then stall_mem=1, stall_wb=0 -> wb_wreg=0, wb_wd=0 next cycle.
- Flush priority: flush=1 together with stall_mem=0 and mem_wreg=1, mem_whilo=1 -> next cycle wb_wreg=0, wb_whilo=0, wb_wdata=0.
- Back-to-back: ADDU ($3 <= 0x5) followed by LW ($3 <= 0x7) on consecutive cycles -> wb_wd=3, wb_wdata=0x5, then 0x7. Regfile read of $3 in the same cycle returns the forwarded wb_wdata.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB boundary: load-op codes, stall
// vector bit positions and the register-bus aliases used by the core.
package mem_wb_stage_pkg;

   localparam int REG_BUS_W      = 32;
   localparam int REG_ADDR_BUS_W = 5;

   typedef logic [REG_BUS_W-1:0]      reg_bus_t;
   typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_t;

   localparam reg_bus_t ZERO_WORD     = '0;
   localparam logic     WRITE_ENABLE  = 1'b1;
   localparam logic     WRITE_DISABLE = 1'b0;

   localparam int STALL_MEM_BIT = 4;
   localparam int STALL_WB_BIT  = 5;

   typedef enum logic [2:0] {
      LOAD_OP_NONE = 3'd0,
      LOAD_OP_LB   = 3'd1,
      LOAD_OP_LBU  = 3'd2,
      LOAD_OP_LH   = 3'd3,
      LOAD_OP_LHU  = 3'd4,
      LOAD_OP_LW   = 3'd5,
      LOAD_OP_LWL  = 3'd6,
      LOAD_OP_LWR  = 3'd7
   } load_op_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: MEM-stage result and pipeline control in, register
// file and HI/LO write ports out.
interface mem_wb_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              stall_mem;
   logic              stall_wb;
   logic              flush;
   logic [REG_AW-1:0] mem_wd;
   logic              mem_wreg;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_load_op;
   logic [1:0]        mem_addr_lo;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] mem_rt_old;
   logic              mem_whilo;
   logic [DATA_W-1:0] mem_hi;
   logic [DATA_W-1:0] mem_lo;

   logic [REG_AW-1:0] wb_wd;
   logic              wb_wreg;
   logic [DATA_W-1:0] wb_wdata;
   logic              wb_whilo;
   logic [DATA_W-1:0] wb_hi;
   logic [DATA_W-1:0] wb_lo;

   modport master (
      output stall_mem, stall_wb, flush, mem_wd, mem_wreg, mem_wdata,
             mem_load_op, mem_addr_lo, mem_rdata, mem_rt_old,
             mem_whilo, mem_hi, mem_lo,
      input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
   );

   modport slave (
      input  stall_mem, stall_wb, flush, mem_wd, mem_wreg, mem_wdata,
             mem_load_op, mem_addr_lo, mem_rdata, mem_rt_old,
             mem_whilo, mem_hi, mem_lo,
      output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
   );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load extraction: picks the addressed byte/half, extends it, and
// performs the LWL/LWR merges with the old rt value. Purely combinational.
module load_align
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        load_op,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] rt_old,
   input  logic [DATA_W-1:0] wdata_in,
   output logic [DATA_W-1:0] wdata_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane 0 is the most significant byte; addr_lo[0] never matters for halves
   // because misaligned halfword loads trap in MEM.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[31:24];
         2'd1:    byte_sel = rdata[23:16];
         2'd2:    byte_sel = rdata[15:8];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      wdata_out = wdata_in;
      case (load_op_e'(load_op))
         LOAD_OP_LB:  wdata_out = {{24{byte_sel[7]}}, byte_sel};
         LOAD_OP_LBU: wdata_out = {24'd0, byte_sel};
         LOAD_OP_LH:  wdata_out = {{16{half_sel[15]}}, half_sel};
         LOAD_OP_LHU: wdata_out = {16'd0, half_sel};
         LOAD_OP_LW:  wdata_out = rdata;
         LOAD_OP_LWL: begin
            case (addr_lo)
               2'd0:    wdata_out = rdata;
               2'd1:    wdata_out = {rdata[23:0], rt_old[7:0]};
               2'd2:    wdata_out = {rdata[15:0], rt_old[15:0]};
               default: wdata_out = {rdata[7:0],  rt_old[23:0]};
            endcase
         end
         LOAD_OP_LWR: begin
            case (addr_lo)
               2'd0:    wdata_out = {rt_old[31:8],  rdata[31:24]};
               2'd1:    wdata_out = {rt_old[31:16], rdata[31:16]};
               2'd2:    wdata_out = {rt_old[31:24], rdata[31:8]};
               default: wdata_out = rdata;
            endcase
         end
         default:     wdata_out = wdata_in;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Flush and a MEM-only stall insert a bubble so
// WB never sees a stale write; a full stall holds everything.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);

   logic [DATA_W-1:0] load_wdata;

   logic [REG_AW-1:0] wd_d, wd_q;
   logic              wreg_d, wreg_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic              whilo_d, whilo_q;
   logic [DATA_W-1:0] hi_d, hi_q;
   logic [DATA_W-1:0] lo_d, lo_q;

   logic bubble, capture;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .load_op   (bus.mem_load_op),
      .addr_lo   (bus.mem_addr_lo),
      .rdata     (bus.mem_rdata),
      .rt_old    (bus.mem_rt_old),
      .wdata_in  (bus.mem_wdata),
      .wdata_out (load_wdata)
   );

   assign bubble  = bus.flush || (bus.stall_mem && !bus.stall_wb);
   assign capture = !bus.stall_mem;

   always_comb begin
      wd_d    = wd_q;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      whilo_d = whilo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (bubble) begin
         wd_d    = '0;
         wreg_d  = WRITE_DISABLE;
         wdata_d = '0;
         whilo_d = WRITE_DISABLE;
         hi_d    = '0;
         lo_d    = '0;
      end else if (capture) begin
         wd_d    = bus.mem_wd;
         wreg_d  = bus.mem_wreg;
         wdata_d = load_wdata;
         whilo_d = bus.mem_whilo;
         hi_d    = bus.mem_hi;
         lo_d    = bus.mem_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q    <= '0;
         wreg_q  <= WRITE_DISABLE;
         wdata_q <= '0;
         whilo_q <= WRITE_DISABLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         wd_q    <= wd_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         whilo_q <= whilo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.wb_wd    = wd_q;
   assign bus.wb_wreg  = wreg_q;
   assign bus.wb_wdata = wdata_q;
   assign bus.wb_whilo = whilo_q;
   assign bus.wb_hi    = hi_q;
   assign bus.wb_lo    = lo_q;

   // ctrl must never release MEM while WB is still stalled
   a_stall_order: assert property (@(posedge clk) disable iff (rst)
      !(!bus.stall_mem && bus.stall_wb));

endmodule
